// File: rtl/hamming_pkg.sv
// Shared definitions for the hamming BIST slice.
// Widths, error position range and the BIST FSM state encoding.
package hamming_pkg;

    localparam int DATA_W = 16;
    localparam int CODE_W = 21;
    localparam int N_POS  = 21;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/hamming_bist_ctrl_err_injector.sv
// Single-bit error injector between encoder and decoder.
// Ports: code (in), pos (bit index), en (inject), code_out (code ^ (en << pos)).
module err_injector
    import hamming_pkg::*;
#(
    parameter int CODE_W_P = CODE_W
) (
    input  logic [CODE_W_P-1:0] code,
    input  logic [4:0]          pos,
    input  logic                en,
    output logic [CODE_W_P-1:0] code_out
);

    assign code_out = code ^ (CODE_W_P'(en) << pos);

endmodule

// File: rtl/hamming_bist_ctrl.sv
// BIST sequencer: steps the LFSR, feeds the encoder, optionally corrupts one
// codeword bit and checks decoder word/err flag. Ports: start/vec_count/inject_en
// control, gen_* LFSR, enc_* encoder, dec_* decoder, busy/done/pass and counters.
module hamming_bist_ctrl
    import hamming_pkg::*;
#(
    parameter int DATA_W_P    = DATA_W,
    parameter int CODE_W_P    = CODE_W,
    parameter int ENC_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         vec_count,
    input  logic                inject_en,
    output logic                gen_en,
    input  logic [15:0]         gen_data,
    output logic [DATA_W_P-1:0] enc_data,
    input  logic [CODE_W_P-1:0] enc_code,
    output logic [CODE_W_P-1:0] dec_code,
    input  logic [DATA_W_P-1:0] dec_data,
    input  logic                dec_err,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         fail_cnt,
    output logic [15:0]         err_flag_cnt,
    output logic [4:0]          err_pos,
    output logic [DATA_W_P-1:0] first_fail_data
);

    state_t              state, state_n;
    logic [15:0]         vec_left;
    logic                inj_r;
    logic [DATA_W_P-1:0] exp_r;
    logic [7:0]          wait_cnt;
    logic                vec_fail;
    logic                mask_en;

    // Mask is only live while the decoder result is being judged.
    assign mask_en  = (state == CHECK) && inj_r;
    assign vec_fail = (dec_data != exp_r) || (dec_err != inj_r);

    err_injector #(.CODE_W_P(CODE_W_P)) u_inj (
        .code     (enc_code),
        .pos      (err_pos),
        .en       (mask_en),
        .code_out (dec_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        gen_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        pass    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                pass = (state == DONE) && (fail_cnt == 16'd0);
                if (start)
                    state_n = (vec_count == 16'd0) ? DONE : ISSUE;
            end
            ISSUE: begin
                busy    = 1'b1;
                gen_en  = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_cnt <= 8'd1) state_n = CHECK;
            end
            CHECK: begin
                busy    = 1'b1;
                state_n = (vec_left == 16'd1) ? DONE : ISSUE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_left        <= '0;
            inj_r           <= 1'b0;
            exp_r           <= '0;
            wait_cnt        <= '0;
            enc_data        <= '0;
            fail_cnt        <= '0;
            err_flag_cnt    <= '0;
            err_pos         <= '0;
            first_fail_data <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec_left        <= vec_count;
                        inj_r           <= inject_en;
                        fail_cnt        <= '0;
                        err_flag_cnt    <= '0;
                        err_pos         <= '0;
                        first_fail_data <= '0;
                    end
                end
                ISSUE: begin
                    enc_data <= gen_data;
                    exp_r    <= gen_data;
                    wait_cnt <= 8'(ENC_LATENCY);
                end
                WAIT: wait_cnt <= wait_cnt - 8'd1;
                CHECK: begin
                    if (vec_fail) begin
                        if (fail_cnt == 16'd0) first_fail_data <= exp_r;
                        if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
                    end
                    if (dec_err && err_flag_cnt != 16'hFFFF)
                        err_flag_cnt <= err_flag_cnt + 16'd1;
                    if (inj_r)
                        err_pos <= (err_pos == 5'(N_POS - 1)) ? 5'd0 : err_pos + 5'd1;
                    vec_left <= vec_left - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
